// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
//
// Emulates a 4x4 matrix keypad towards a column-scanning controller. Key
// requests are queued in a 4-deep FIFO and "pressed" one at a time. Each key
// is held for HOLD_CYCLES clocks, then released for GAP_CYCLES clocks before
// the next key is taken from the queue.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   key_valid  request to press key_code
//   key_code   key to press; 0x0-0xF valid, 0x10-0x1F rejected with err
//   key_ready  queue can accept a request this cycle
//   Col        active-low column drive from the scanner
//   Row        active-low row response to the scanner
//   pressed    high while a key is being held
//   busy       high while a key is in progress or keys are queued
//   err        one-cycle pulse after an invalid code was accepted
//
// Build option:
//   KYPD_BOUNCE_EN  when defined, the row output chatters (follows counter
//                   bit 9) during the first BOUNCE_CYCLES cycles of a press.
// -----------------------------------------------------------------------------
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 1000000,
    parameter int GAP_CYCLES    = 500000,
    parameter int BOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic       key_ready,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    output logic       pressed,
    output logic       busy,
    output logic       err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  curKey_q, curKey_d;
    logic [3:0]  fifoMem_q [4];
    logic [1:0]  wrPtr_q, rdPtr_q;
    logic [2:0]  fifoCount_q;
    logic        readyEn_q;
    logic        err_q;
    logic        pressed_q;
    logic [3:0]  row_q, row_d;

    logic        accept, push, pop;
    logic [1:0]  keyCol, keyRow;
    logic        colDriven, rowEnable;

    // readyEn_q keeps key_ready low while in reset and lets it rise on the
    // first clock edge afterwards.
    assign key_ready = readyEn_q & (fifoCount_q != 3'd4);
    assign accept    = key_valid & key_ready;
    assign push      = accept & ~key_code[4];
    assign pop       = (state_q == ST_IDLE) & (fifoCount_q != 3'd0);

    // Sequencer: take the queue head in IDLE, hold it, then enforce a gap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        curKey_d = curKey_q;
        case (state_q)
            ST_IDLE: begin
                if (fifoCount_q != 3'd0) begin
                    state_d  = ST_HOLD;
                    cnt_d    = 24'd0;
                    curKey_d = fifoMem_q[rdPtr_q];
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = 24'd0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 24'd0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 24'd0;
            end
        endcase
    end

    // Key position in the matrix (column index, row index).
    always_comb begin
        keyCol = 2'd0;
        keyRow = 2'd0;
        case (curKey_q)
            4'h1: begin keyCol = 2'd0; keyRow = 2'd0; end
            4'h4: begin keyCol = 2'd0; keyRow = 2'd1; end
            4'h7: begin keyCol = 2'd0; keyRow = 2'd2; end
            4'h0: begin keyCol = 2'd0; keyRow = 2'd3; end
            4'h2: begin keyCol = 2'd1; keyRow = 2'd0; end
            4'h5: begin keyCol = 2'd1; keyRow = 2'd1; end
            4'h8: begin keyCol = 2'd1; keyRow = 2'd2; end
            4'hF: begin keyCol = 2'd1; keyRow = 2'd3; end
            4'h3: begin keyCol = 2'd2; keyRow = 2'd0; end
            4'h6: begin keyCol = 2'd2; keyRow = 2'd1; end
            4'h9: begin keyCol = 2'd2; keyRow = 2'd2; end
            4'hE: begin keyCol = 2'd2; keyRow = 2'd3; end
            4'hA: begin keyCol = 2'd3; keyRow = 2'd0; end
            4'hB: begin keyCol = 2'd3; keyRow = 2'd1; end
            4'hC: begin keyCol = 2'd3; keyRow = 2'd2; end
            default: begin keyCol = 2'd3; keyRow = 2'd3; end
        endcase
    end

    // Only the key's own column line matters; other low columns are ignored.
    assign colDriven = ~Col[2'd3 - keyCol];

`ifdef KYPD_BOUNCE_EN
    localparam logic [23:0] BOUNCE_LIM = 24'(BOUNCE_CYCLES);
    // Contact chatter: early in the press the row follows counter bit 9.
    assign rowEnable = (cnt_q >= BOUNCE_LIM) | cnt_q[9];
`else
    logic unusedBounce;
    assign unusedBounce = (BOUNCE_CYCLES != 0);
    assign rowEnable    = 1'b1;
`endif

    assign row_d = (state_q == ST_HOLD && colDriven && rowEnable) ?
                   ~(4'b1000 >> keyRow) : 4'b1111;

    // Sequencer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 24'd0;
            curKey_q  <= 4'h0;
            readyEn_q <= 1'b0;
            err_q     <= 1'b0;
            pressed_q <= 1'b0;
            row_q     <= 4'b1111;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            curKey_q  <= curKey_d;
            readyEn_q <= 1'b1;
            err_q     <= accept & key_code[4];
            pressed_q <= (state_d == ST_HOLD);
            row_q     <= row_d;
        end
    end

    // Request FIFO; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifoMem_q   <= '{default: 4'h0};
            wrPtr_q     <= 2'd0;
            rdPtr_q     <= 2'd0;
            fifoCount_q <= 3'd0;
        end else begin
            if (push) begin
                fifoMem_q[wrPtr_q] <= key_code[3:0];
                wrPtr_q            <= wrPtr_q + 2'd1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            if (push && !pop) begin
                fifoCount_q <= fifoCount_q + 3'd1;
            end else if (pop && !push) begin
                fifoCount_q <= fifoCount_q - 3'd1;
            end
        end
    end

    assign Row     = row_q;
    assign pressed = pressed_q;
    assign err     = err_q;
    assign busy    = (state_q != ST_IDLE) | (fifoCount_q != 3'd0);

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
//
// Self-checking bench for keypad_emulator. Queued keys are pushed to a
// scoreboard when requested; a monitor pops them as presses begin and predicts
// Row every cycle from the key map, the previous cycle's pressed flag and the
// Col value seen at the clock edge. A vector table covers the key map and the
// invalid-code path; hand-written sequences cover column scanning, a full
// queue with back-to-back keys, and reset in the middle of a press.
// -----------------------------------------------------------------------------
module tb_keypad_emulator;

`ifdef KYPD_BOUNCE_EN
    localparam int HOLD_P    = 4608;
    localparam int SETTLE    = 4097;
    localparam int TABLE_RUN = 2;
`else
    localparam int HOLD_P    = 64;
    localparam int SETTLE    = 1;
    localparam int TABLE_RUN = 12;
`endif
    localparam int GAP_P    = 32;
    localparam int BOUNCE_P = 4096;
    localparam int KEY_SPAN = HOLD_P + GAP_P + 8;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready;
    logic [3:0] Col;
    logic [3:0] Row;
    logic       pressed;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    keypad_emulator #(
        .HOLD_CYCLES  (HOLD_P),
        .GAP_CYCLES   (GAP_P),
        .BOUNCE_CYCLES(BOUNCE_P)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .Col      (Col),
        .Row      (Row),
        .pressed  (pressed),
        .busy     (busy),
        .err      (err)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog in case something stalls outside the bounded waits.
    initial begin
        #(64'(30) * KEY_SPAN * 10);
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Key map model: column index and row index of each key.
    function automatic logic [1:0] modelCol(input logic [3:0] k);
        case (k)
            4'h1, 4'h4, 4'h7, 4'h0: return 2'd0;
            4'h2, 4'h5, 4'h8, 4'hF: return 2'd1;
            4'h3, 4'h6, 4'h9, 4'hE: return 2'd2;
            default:                return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] modelRow(input logic [3:0] k);
        case (k)
            4'h1, 4'h2, 4'h3, 4'hA: return 2'd0;
            4'h4, 4'h5, 4'h6, 4'hB: return 2'd1;
            4'h7, 4'h8, 4'h9, 4'hC: return 2'd2;
            default:                return 2'd3;
        endcase
    endfunction

    // Scoreboard and monitor state.
    logic [3:0] expQ [$];
    logic [3:0] curKey      = 4'h0;
    logic       prevPressed = 1'b0;
    logic [3:0] colAtEdge   = 4'hF;
    int         holdLen     = 0;
    int         prevHoldLen = 0;
    int         gapLen      = 0;
    bit         havePrev    = 0;
    bit         checkGap    = 0;
    logic [3:0] expRow;
    logic [1:0] mc, mr;
    int         cntPrev;
    bit         allow;

    // Col as the DUT sees it on the rising edge.
    always @(posedge clk) colAtEdge = Col;

    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            prevPressed = 1'b0;
            holdLen     = 0;
            prevHoldLen = 0;
            gapLen      = 0;
            havePrev    = 0;
        end else begin
            mc      = modelCol(curKey);
            mr      = modelRow(curKey);
            cntPrev = prevHoldLen - 1;
            allow   = 1'b1;
`ifdef KYPD_BOUNCE_EN
            allow   = (cntPrev >= BOUNCE_P) || cntPrev[9];
`endif
            expRow = 4'b1111;
            if (prevPressed && !colAtEdge[2'd3 - mc] && allow) expRow[2'd3 - mr] = 1'b0;
            checkOutput("row_model", Row, expRow);

            if (pressed && !prevPressed) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_press actual=pressed required=idle at %0t", $time);
                end else begin
                    curKey = expQ.pop_front();
                end
                if (havePrev && checkGap) checkOutput("gap_len", gapLen, GAP_P + 1);
                holdLen = 0;
            end
            if (!pressed && prevPressed) begin
                checkOutput("hold_len", holdLen, HOLD_P);
                havePrev = 1;
                gapLen   = 0;
            end
            if (pressed) holdLen++;
            else         gapLen++;
            if (!busy) havePrev = 0;
            prevPressed = pressed;
            prevHoldLen = holdLen;
        end
    end

    // Drives one request for a cycle once key_ready allows it; called on a
    // falling edge and returns on the falling edge after the accepting edge.
    task automatic applyStimulus(input logic [4:0] code);
        int n = 0;
        while (!key_ready && n < KEY_SPAN * 6) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout actual=%0b required=1 code=%0h", key_ready, code);
        end else begin
            key_valid = 1'b1;
            key_code  = code;
            if (!code[4]) expQ.push_back(code[3:0]);
            @(negedge clk);
            key_valid = 1'b0;
        end
    endtask

    task automatic waitPressed(input int budget);
        int n = 0;
        while (!pressed && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("press_seen", pressed, 1'b1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_seen", busy, 1'b0);
    endtask

    typedef struct {
        logic [4:0] code;
        logic [3:0] col;
        logic [3:0] expRow;
        logic       expErr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        bit sawRelease;
        int n;

        vecs[0]  = '{5'h05, 4'b1011, 4'b1011, 1'b0};
        vecs[1]  = '{5'h0D, 4'b1110, 4'b1110, 1'b0};
        vecs[2]  = '{5'h08, 4'b1011, 4'b1101, 1'b0};
        vecs[3]  = '{5'h0A, 4'b1110, 4'b0111, 1'b0};
        vecs[4]  = '{5'h00, 4'b0111, 4'b1110, 1'b0};
        vecs[5]  = '{5'h0F, 4'b1011, 4'b1110, 1'b0};
        vecs[6]  = '{5'h0E, 4'b1101, 4'b1110, 1'b0};
        vecs[7]  = '{5'h01, 4'b0111, 4'b0111, 1'b0};
        vecs[8]  = '{5'h05, 4'b1101, 4'b1111, 1'b0};
        vecs[9]  = '{5'h09, 4'b0000, 4'b1101, 1'b0};
        vecs[10] = '{5'h0C, 4'b1111, 4'b1111, 1'b0};
        vecs[11] = '{5'h13, 4'b1111, 4'b1111, 1'b1};

        // Reset state before any clock edge.
        rst_n     = 1'b1;
        key_valid = 1'b0;
        key_code  = 5'h00;
        Col       = 4'b1111;
        #1 rst_n  = 1'b0;
        #2;
        checkOutput("reset_row", Row, 4'b1111);
        checkOutput("reset_pressed", pressed, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_err", err, 1'b0);
        checkOutput("reset_ready", key_ready, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_ready_clocked", key_ready, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", key_ready, 1'b1);

        // Key map table, wrong/multiple/no column drive, and an invalid code.
        for (int i = 0; i < TABLE_RUN; i++) begin
            Col = vecs[i].col;
            applyStimulus(vecs[i].code);
            if (vecs[i].expErr) begin
                checkOutput("err_pulse", err, 1'b1);
                checkOutput("busy_invalid", busy, 1'b0);
                @(negedge clk);
                checkOutput("err_clear", err, 1'b0);
                checkOutput("busy_invalid_after", busy, 1'b0);
                checkOutput("row_invalid", Row, vecs[i].expRow);
            end else begin
                waitPressed(8);
                repeat (SETTLE) @(negedge clk);
                checkOutput("table_row", Row, vecs[i].expRow);
                waitIdle(KEY_SPAN);
            end
        end

        // Key D while the scanner walks the columns every 8 cycles.
        Col = 4'b0111;
        applyStimulus(5'h0D);
        for (int k = 0; k < KEY_SPAN; k++) begin
            case ((k / 8) % 4)
                0:       Col = 4'b0111;
                1:       Col = 4'b1011;
                2:       Col = 4'b1101;
                default: Col = 4'b1110;
            endcase
            @(negedge clk);
        end
        waitIdle(KEY_SPAN);

        // Five keys back-to-back: key 1 goes straight to HOLD, 2..5 fill the
        // queue, and space reopens exactly when key 2 is popped.
        Col      = 4'b0101;
        checkGap = 1;
        for (int k = 1; k <= 5; k++) applyStimulus(5'(k));
        checkOutput("ready_full", key_ready, 1'b0);
        checkOutput("busy_full", busy, 1'b1);
        sawRelease = 0;
        n = 0;
        while (!key_ready && n < KEY_SPAN * 2) begin
            @(negedge clk);
            if (!pressed) sawRelease = 1;
            n++;
        end
        checkOutput("ready_reopen", key_ready, 1'b1);
        checkOutput("ready_reopen_pressed", pressed, 1'b1);
        checkOutput("ready_reopen_after_release", sawRelease, 1'b1);
        waitIdle(KEY_SPAN * 6);
        checkGap = 0;
        checkOutput("queue_drained", expQ.size(), 0);

        // Asynchronous reset in the middle of holding key A.
        Col = 4'b1110;
        applyStimulus(5'h0A);
        waitPressed(8);
        repeat (SETTLE + 4) @(negedge clk);
        checkOutput("row_before_reset", Row, 4'b0111);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_row", Row, 4'b1111);
        checkOutput("async_pressed", pressed, 1'b0);
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_ready", key_ready, 1'b0);
        checkOutput("async_err", err, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", busy, 1'b0);
        checkOutput("post_reset_ready", key_ready, 1'b1);
        checkOutput("post_reset_row", Row, 4'b1111);
        repeat (5) @(negedge clk);
        checkOutput("post_reset_idle", pressed, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
